token_queue_fwft: RTL and testbench

Parametrised first-word-fall-through queue for the pre-parser slices feeding the snappy decompressor's second-level parser. It packs the slice fields (data, token position, address, garbage count, literal flag) into one entry and stores them in an inferred RAM, not vendor FIFO IP. The output side uses a valid/read handshake. It adds what the previous token queue lacked: configurable depth and field widths, programmable almost-full/almost-empty thresholds, an occupancy count, synchronous flush, and sticky overflow/underflow flags.

---
 rtl/token_pkg.sv | 29 ++
 rtl/token_queue_mem.sv | 35 +++
 rtl/token_queue_fwft.sv | 130 +++++++++++++
 tb/tb_token_queue_fwft.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/token_pkg.sv
// Slice-entry field widths and pack/unpack helpers shared by the pre-parser,
// the token queue and the second-level parser.
package token_pkg;

  localparam int unsigned TOKEN_DATA_W = 144;
  localparam int unsigned TOKEN_POS_W  = 16;
  localparam int unsigned TOKEN_ADDR_W = 17;
  localparam int unsigned TOKEN_GARB_W = 3;
  localparam int unsigned TOKEN_W      = TOKEN_DATA_W + TOKEN_POS_W + TOKEN_ADDR_W
                                         + TOKEN_GARB_W + 1;

  // Declaration order fixes the packing order: data sits in the MSBs.
  typedef struct packed {
    logic [TOKEN_DATA_W-1:0] data;
    logic [TOKEN_POS_W-1:0]  position;
    logic [TOKEN_ADDR_W-1:0] address;
    logic [TOKEN_GARB_W-1:0] garbage;
    logic                    lit_flag;
  } token_t;

  function automatic logic [TOKEN_W-1:0] token_pack(input token_t t);
    return TOKEN_W'(t);
  endfunction

  function automatic token_t token_unpack(input logic [TOKEN_W-1:0] v);
    return token_t'(v);
  endfunction

endpackage

// File: rtl/token_queue_mem.sv
// Simple dual-port RAM: one write port and one registered read port whose
// read register doubles as the queue's output register.
module token_queue_mem
  import token_pkg::*;
#(
  parameter int unsigned W     = TOKEN_W,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Holds its value between reads so fields stay put after the last pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/token_queue_fwft.sv
// First-word-fall-through token queue: inferred RAM plus output register,
// registered status, programmable thresholds, flush and sticky error flags.
module token_queue_fwft
  import token_pkg::*;
#(
  parameter int unsigned DATA_W    = TOKEN_DATA_W,
  parameter int unsigned POS_W     = TOKEN_POS_W,
  parameter int unsigned ADDR_W    = TOKEN_ADDR_W,
  parameter int unsigned GARB_W    = TOKEN_GARB_W,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AFULL_TH  = DEPTH - 8,
  parameter int unsigned AEMPTY_TH = 2,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [POS_W-1:0]  position_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [GARB_W-1:0] garbage_in,
  input  logic              lit_flag_in,
  input  logic              wrreq,
  input  logic              rdreq,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic [POS_W-1:0]  position_out,
  output logic [ADDR_W-1:0] address_out,
  output logic [GARB_W-1:0] garbage_out,
  output logic              lit_flag_out,
  output logic              valid_out,
  output logic              isempty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned W = DATA_W + POS_W + ADDR_W + GARB_W + 1;

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_ram_cnt, r_count;
  logic          r_valid, r_isempty, r_full, r_afull, r_aempty, r_ovf, r_unf;

  logic          w_wr_acc, w_pop, w_load, w_valid_d;
  logic [CW-1:0] w_ram_cnt_d, w_count_d;
  logic [W-1:0]  w_wr_data, w_rd_data;

  assign w_wr_acc    = wrreq & ~r_full & ~flush;
  assign w_pop       = rdreq & r_valid & ~flush;
  // Refill the output register whenever it is vacant or being consumed.
  assign w_load      = (~r_valid | w_pop) & (r_ram_cnt != '0) & ~flush;
  assign w_ram_cnt_d = r_ram_cnt + CW'(w_wr_acc) - CW'(w_load);
  assign w_valid_d   = w_load | (r_valid & ~w_pop);
  assign w_count_d   = w_ram_cnt_d + CW'(w_valid_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_isempty <= 1'b1;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_isempty <= 1'b1;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_cnt <= w_ram_cnt_d;
      r_valid   <= w_valid_d;
      r_count   <= w_count_d;
      r_isempty <= (w_count_d == '0);
      r_full    <= (w_count_d == CW'(DEPTH));
      r_afull   <= (32'(w_count_d) >= AFULL_TH);
      r_aempty  <= (32'(w_count_d) <= AEMPTY_TH);
      if (wrreq & r_full)   r_ovf <= 1'b1;
      if (rdreq & ~r_valid) r_unf <= 1'b1;
    end
  end

  assign w_wr_data = {data_in, position_in, address_in, garbage_in, lit_flag_in};

  token_queue_mem #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_load),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign data_out     = w_rd_data[W-1 -: DATA_W];
  assign position_out = w_rd_data[W-DATA_W-1 -: POS_W];
  assign address_out  = w_rd_data[ADDR_W+GARB_W -: ADDR_W];
  assign garbage_out  = w_rd_data[GARB_W -: GARB_W];
  assign lit_flag_out = w_rd_data[0];

  assign valid_out    = r_valid;
  assign isempty      = r_isempty;
  assign full         = r_full;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_token_queue_fwft.sv
// Bench for token_queue_fwft: table-driven vectors, scoreboard of written
// entries, and hand sequences for fill, wrap, flush, thresholds and reset.
module tb_token_queue_fwft;
  import token_pkg::*;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned AFULL_TH = DEPTH - 8;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [TOKEN_DATA_W-1:0] data_in = '0;
  logic [TOKEN_POS_W-1:0]  position_in = '0;
  logic [TOKEN_ADDR_W-1:0] address_in = '0;
  logic [TOKEN_GARB_W-1:0] garbage_in = '0;
  logic                    lit_flag_in = 1'b0;
  logic                    wrreq = 1'b0, rdreq = 1'b0, flush = 1'b0;
  logic [TOKEN_DATA_W-1:0] data_out;
  logic [TOKEN_POS_W-1:0]  position_out;
  logic [TOKEN_ADDR_W-1:0] address_out;
  logic [TOKEN_GARB_W-1:0] garbage_out;
  logic                    lit_flag_out, valid_out, isempty, full;
  logic                    almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]           count;

  token_queue_fwft #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .position_in  (position_in),
    .address_in   (address_in),
    .garbage_in   (garbage_in),
    .lit_flag_in  (lit_flag_in),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .flush        (flush),
    .data_out     (data_out),
    .position_out (position_out),
    .address_out  (address_out),
    .garbage_out  (garbage_out),
    .lit_flag_out (lit_flag_out),
    .valid_out    (valid_out),
    .isempty      (isempty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail = 0;
  token_t sb[$];
  int     m_cnt = 0, m_ram = 0;
  bit     m_valid = 0, m_ovf = 0, m_unf = 0;

  typedef struct {
    bit wr, rd, fl;
    int exp_cnt;
    bit exp_valid, exp_ae, exp_unf;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic token_t cur_head();
    token_t h;
    h.data     = data_out;
    h.position = position_out;
    h.address  = address_out;
    h.garbage  = garbage_out;
    h.lit_flag = lit_flag_out;
    return h;
  endfunction

  function automatic logic [13:0] dut_status();
    return {count, valid_out, isempty, full, almost_full, almost_empty, overflow, underflow};
  endfunction

  function automatic logic [13:0] model_status();
    return {7'(m_cnt), m_valid, m_cnt == 0, m_cnt == int'(DEPTH), m_cnt >= int'(AFULL_TH),
            m_cnt <= 2, m_ovf, m_unf};
  endfunction

  function automatic token_t spec_tok(input int k);
    token_t t;
    for (int j = 0; j < 18; j++) t.data[8*(17-j) +: 8] = 8'(j + 1 + 32 * k);
    t.position = 16'd5;
    t.address  = 17'h1FFFF;
    t.garbage  = 3'd7;
    t.lit_flag = 1'b1;
    return t;
  endfunction

  function automatic token_t rand_tok();
    token_t t;
    for (int j = 0; j < 18; j++) t.data[8*j +: 8] = 8'($urandom);
    t.position = 16'($urandom);
    t.address  = 17'($urandom);
    t.garbage  = 3'($urandom);
    t.lit_flag = 1'($urandom);
    return t;
  endfunction

  function automatic void model_clear();
    m_cnt = 0; m_ram = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    sb.delete();
  endfunction

  // One clock: drive, check popped head against scoreboard, advance model, check status.
  task automatic step(input bit wr, input bit rd, input bit fl, input token_t t);
    bit     pop, wacc, load;
    token_t exp;
    wrreq = wr; rdreq = rd; flush = fl;
    data_in = t.data; position_in = t.position; address_in = t.address;
    garbage_in = t.garbage; lit_flag_in = t.lit_flag;
    pop  = rd && m_valid && !fl;
    wacc = wr && (m_cnt < int'(DEPTH)) && !fl;
    load = (!m_valid || pop) && (m_ram > 0) && !fl;
    if (pop) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pop_data: pop with no expected entry");
      end else begin
        exp = sb.pop_front();
        check("pop_data", 256'(token_pack(cur_head())), 256'(token_pack(exp)));
      end
    end
    if (fl) model_clear();
    else begin
      if (wr && m_cnt == int'(DEPTH)) m_ovf = 1;
      if (rd && !m_valid) m_unf = 1;
      if (wacc) sb.push_back(t);
      m_ram   = m_ram + int'(wacc) - int'(load);
      m_valid = load || (m_valid && !pop);
      m_cnt   = m_ram + int'(m_valid);
    end
    @(posedge clk);
    #1;
    check("status", 256'(dut_status()), 256'(model_status()));
    wrreq = 0; rdreq = 0; flush = 0;
  endtask

  initial begin
    int     wk;
    int     bubbles;
    token_t t0;

    tbl[0] = '{1, 0, 0, 1, 0, 1, 0};
    tbl[1] = '{1, 0, 0, 2, 1, 1, 0};
    tbl[2] = '{1, 0, 0, 3, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 3, 1, 0, 0};
    tbl[4] = '{0, 1, 0, 2, 1, 1, 0};
    tbl[5] = '{0, 1, 0, 1, 1, 1, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 1, 0};
    tbl[7] = '{0, 1, 0, 0, 0, 1, 1};
    tbl[8] = '{0, 0, 1, 0, 0, 1, 0};

    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_status", 256'(dut_status()), 256'(14'b0000000_0_1_0_0_1_0_0));
    check("rst_fields", 256'(token_pack(cur_head())), 256'(0));

    // Three spec writes, latency, unpacking, pops, underflow, flush
    wk = 0;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].fl, spec_tok(wk));
      if (tbl[i].wr) wk++;
      check("tbl_count", 256'(count), 256'(tbl[i].exp_cnt));
      check("tbl_valid", 256'(valid_out), 256'(tbl[i].exp_valid));
      check("tbl_aempty", 256'(almost_empty), 256'(tbl[i].exp_ae));
      check("tbl_underflow", 256'(underflow), 256'(tbl[i].exp_unf));
      if (i == 1) begin
        t0 = spec_tok(0);
        check("unpack_data", 256'(data_out), 256'(t0.data));
        check("unpack_pos", 256'(position_out), 256'(16'd5));
        check("unpack_addr", 256'(address_out), 256'(17'h1FFFF));
        check("unpack_garb", 256'(garbage_out), 256'(3'd7));
        check("unpack_lit", 256'(lit_flag_out), 256'(1'b1));
      end
    end

    // Fill, overflow, drain in order
    for (int i = 0; i < int'(DEPTH); i++) step(1, 0, 0, rand_tok());
    step(1, 0, 0, rand_tok());
    check("fill_full", 256'(full), 256'(1'b1));
    check("fill_count", 256'(count), 256'(DEPTH));
    check("fill_overflow", 256'(overflow), 256'(1'b1));
    for (int i = 0; i < int'(DEPTH); i++) step(0, 1, 0, rand_tok());
    check("drain_empty", 256'(isempty), 256'(1'b1));
    step(0, 0, 1, rand_tok());

    // Streaming write+pop across several pointer wraps
    for (int i = 0; i < 4; i++) step(1, 0, 0, rand_tok());
    step(0, 0, 0, rand_tok());
    bubbles = 0;
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      if (valid_out !== 1'b1) bubbles++;
      step(1, 1, 0, rand_tok());
    end
    check("stream_bubbles", 256'(bubbles), 256'(0));
    check("stream_count", 256'(count), 256'(4));
    step(0, 0, 1, rand_tok());

    // Underflow on empty, cleared by flush
    step(0, 1, 0, rand_tok());
    check("unf_set", 256'(underflow), 256'(1'b1));
    check("unf_count", 256'(count), 256'(0));
    step(0, 0, 1, rand_tok());
    check("unf_clear", 256'(underflow), 256'(1'b0));

    // Flush wins over simultaneous write and read at count 10
    for (int i = 0; i < 10; i++) step(1, 0, 0, rand_tok());
    step(1, 1, 1, rand_tok());
    check("flush_count", 256'(count), 256'(0));
    check("flush_valid", 256'(valid_out), 256'(1'b0));
    check("flush_empty", 256'(isempty), 256'(1'b1));
    for (int i = 0; i < 3; i++) step(0, 0, 0, rand_tok());
    check("flush_nowrite", 256'(count), 256'(0));

    // almost_full threshold
    for (int i = 0; i < 20; i++) step(1, 0, 0, rand_tok());
    check("af_cnt20", 256'(count), 256'(20));
    for (int i = 20; i < int'(AFULL_TH) - 1; i++) step(1, 0, 0, rand_tok());
    check("af_below", 256'(almost_full), 256'(1'b0));
    step(1, 0, 0, rand_tok());
    check("af_at", 256'(almost_full), 256'(1'b1));
    check("af_cnt", 256'(count), 256'(AFULL_TH));

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("arst_status", 256'(dut_status()), 256'(14'b0000000_0_1_0_0_1_0_0));
    check("arst_fields", 256'(token_pack(cur_head())), 256'(0));
    model_clear();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, rand_tok());
    for (int i = 0; i < 4; i++) step(0, 1, 0, rand_tok());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
